if_id_prefetch_stage: RTL and testbench

- Parametrised successor to the fetch/decode pipeline register.
- Drives the PC and fetches from an external combinational instruction memory.
- Buffers fetched words in a DEPTH-entry prefetch queue, so fetch keeps running while decode is stalled.
- Presents a registered instruction, PC+4 and valid flag to decode. Branch redirect is a synchronous flush of the queue and the ID register, replacing the old asynchronous clear.

---
 rtl/mips_pkg.sv | 9 +
 rtl/if_id_prefetch_fifo.sv | 38 +++
 rtl/if_id_prefetch_stage.sv | 65 ++++++
 tb/tb_if_id_prefetch_stage.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch/decode constants and the prefetch queue entry layout.
package mips_pkg;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } entry_t;
endpackage

// File: rtl/if_id_prefetch_fifo.sv
// prefetch_fifo: power-of-two synchronous FIFO with async reset and sync clear.
module prefetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/if_id_prefetch_stage.sv
// if_id_prefetch_stage: PC, prefetch queue and registered IF/ID boundary with sync branch flush.
module if_id_prefetch_stage import mips_pkg::*; #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall_d,
  input  logic                       pcsrc_d,
  input  logic [XLEN-1:0]            pc_branch_d,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [XLEN-1:0]            imem_rdata,
  output logic [XLEN-1:0]            instr_d,
  output logic [XLEN-1:0]            pc_plus4_d,
  output logic                       valid_d,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic                       stall_f
);
  localparam int CW = $clog2(DEPTH+1);
  logic [XLEN-1:0]   pc_f, pc_next4;
  logic [2*XLEN-1:0] fetched, head, id_next;
  logic              pop, fetch_en, bypass, q_push, q_pop;
  assign pc_next4  = pc_f + XLEN'(INSTR_BYTES);
  assign imem_addr = pc_f;
  assign pop       = !stall_d && !pcsrc_d;
  assign fetch_en  = !pcsrc_d && (q_count < CW'(DEPTH) || pop);
  assign stall_f   = !pcsrc_d && q_count == CW'(DEPTH) && !pop;
  // An empty queue forwards the fetched word straight to ID, keeping the 1-cycle latency.
  assign bypass    = pop && q_count == '0;
  assign q_push    = fetch_en && !bypass;
  assign q_pop     = pop && !bypass;
  assign fetched   = {imem_rdata, pc_next4};
  assign id_next   = bypass ? fetched : head;
  prefetch_fifo #(.W(2*XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pcsrc_d),
    .push  (q_push),
    .pop   (q_pop),
    .din   (fetched),
    .dout  (head),
    .count (q_count)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_f <= RESET_PC;
    else if (pcsrc_d) pc_f <= {pc_branch_d[XLEN-1:2], 2'b00};
    else if (fetch_en) pc_f <= pc_next4;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d    <= NOP_INSTR;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (pcsrc_d) begin
      instr_d    <= NOP_INSTR;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (pop) begin
      {instr_d, pc_plus4_d} <= id_next;
      valid_d               <= 1'b1;
    end
  end
endmodule

// File: tb/tb_if_id_prefetch_stage.sv
// tb_if_id_prefetch_stage: scoreboard bench; imem returns addr ^ 0xA5A5A5A5.
module tb_if_id_prefetch_stage;
  import mips_pkg::*;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);
  logic clk = 1'b0, rst_n = 1'b0, stall_d = 1'b0, pcsrc_d = 1'b0;
  logic [31:0] pc_branch_d = '0, imem_addr, imem_rdata, instr_d, pc_plus4_d;
  logic valid_d, stall_f;
  logic [CW-1:0] q_count;
  int total = 0, bad = 0;
  entry_t sb[$];
  entry_t e;
  logic [31:0] held;
  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ 32'hA5A5_A5A5;
  if_id_prefetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_d(stall_d), .pcsrc_d(pcsrc_d), .pc_branch_d(pc_branch_d),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr_d(instr_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .q_count(q_count), .stall_f(stall_f)
  );
  function automatic entry_t mk(input logic [31:0] a);
    entry_t r;
    r.instr = a ^ 32'hA5A5_A5A5;
    r.pc_plus4 = a + 32'd4;
    return r;
  endfunction
  // The stage must never push into a full queue unless it pops in the same cycle.
  always @(posedge clk) begin
    if (rst_n && dut.q_push && !dut.q_pop && q_count == CW'(DEPTH)) begin
      bad++;
      $display("FAIL push_while_full at %0t: count=%0d", $time, q_count);
    end
  end
  task automatic test_reset;
    #2;
    total++; if (instr_d !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr_d); end
    total++; if (pc_plus4_d !== 32'h0) begin bad++; $display("FAIL rst_pc4 got=%h exp=0", pc_plus4_d); end
    total++; if (valid_d !== 1'b0 || stall_f !== 1'b0) begin bad++; $display("FAIL rst_flags got valid=%b stall_f=%b exp 0 0", valid_d, stall_f); end
    total++; if (q_count !== '0 || imem_addr !== 32'h0) begin bad++; $display("FAIL rst_q_pc got cnt=%0d addr=%h exp 0 0", q_count, imem_addr); end
    @(negedge clk) rst_n = 1'b1;
  endtask
  task automatic test_first;
    sb.push_back(mk(32'h0));
    @(posedge clk); #1;
    e = sb.pop_front();
    total++; if (instr_d !== e.instr || pc_plus4_d !== e.pc_plus4 || valid_d !== 1'b1) begin bad++; $display("FAIL first got=%h/%h/%b exp=%h/%h/1", instr_d, pc_plus4_d, valid_d, e.instr, e.pc_plus4); end
    total++; if (q_count !== '0 || imem_addr !== 32'h4) begin bad++; $display("FAIL first_q got cnt=%0d addr=%h exp 0 4", q_count, imem_addr); end
  endtask
  task automatic test_stall;
    held = instr_d;
    stall_d = 1'b1;
    for (int i = 0; i < 6; i++) begin
      total++; if (q_count !== CW'(i > 4 ? 4 : i) || stall_f !== (i >= 4)) begin bad++; $display("FAIL stall_cnt[%0d] got cnt=%0d sf=%b exp cnt=%0d sf=%b", i, q_count, stall_f, (i > 4 ? 4 : i), (i >= 4)); end
      @(posedge clk); #1;
      total++; if (instr_d !== held) begin bad++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, instr_d, held); end
    end
    total++; if (imem_addr !== 32'h14 || q_count !== CW'(4)) begin bad++; $display("FAIL stall_end got addr=%h cnt=%0d exp 14 4", imem_addr, q_count); end
  endtask
  task automatic test_release;
    stall_d = 1'b0;
    for (int i = 0; i < 8; i++) sb.push_back(mk(32'h4 + 32'(4 * i)));
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      total++; if (instr_d !== e.instr || pc_plus4_d !== e.pc_plus4 || valid_d !== 1'b1) begin bad++; $display("FAIL release[%0d] got=%h/%h exp=%h/%h", i, instr_d, pc_plus4_d, e.instr, e.pc_plus4); end
      total++; if (q_count !== CW'(4)) begin bad++; $display("FAIL release_cnt[%0d] got=%0d exp=4", i, q_count); end
    end
  endtask
  task automatic test_redirect;
    pcsrc_d = 1'b1; pc_branch_d = 32'h200;
    @(posedge clk); #1;
    total++; if (q_count !== '0 || valid_d !== 1'b0 || imem_addr !== 32'h200) begin bad++; $display("FAIL redir1 got cnt=%0d v=%b addr=%h exp 0 0 200", q_count, valid_d, imem_addr); end
    pcsrc_d = 1'b0; stall_d = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (q_count !== CW'(3) || imem_addr !== 32'h20C) begin bad++; $display("FAIL redir_fill got cnt=%0d addr=%h exp 3 20c", q_count, imem_addr); end
    pcsrc_d = 1'b1; pc_branch_d = 32'h103;
    @(posedge clk); #1;
    total++; if (q_count !== '0 || valid_d !== 1'b0 || instr_d !== 32'h0 || imem_addr !== 32'h100) begin bad++; $display("FAIL redir2 got cnt=%0d v=%b i=%h addr=%h exp 0 0 0 100", q_count, valid_d, instr_d, imem_addr); end
    sb.delete();
    pcsrc_d = 1'b0; stall_d = 1'b0;
    sb.push_back(mk(32'h100));
    @(posedge clk); #1;
    e = sb.pop_front();
    total++; if (pc_plus4_d !== 32'h104 || instr_d !== e.instr || valid_d !== 1'b1) begin bad++; $display("FAIL redir_target got=%h/%h exp=%h/104", instr_d, pc_plus4_d, e.instr); end
  endtask
  task automatic test_wrap;
    pcsrc_d = 1'b1; pc_branch_d = 32'hFFFF_FFF8;
    @(posedge clk); #1;
    pcsrc_d = 1'b0;
    sb.push_back(mk(32'hFFFF_FFF8)); sb.push_back(mk(32'hFFFF_FFFC)); sb.push_back(mk(32'h0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      total++; if (instr_d !== e.instr || pc_plus4_d !== e.pc_plus4 || imem_addr !== e.pc_plus4) begin bad++; $display("FAIL wrap[%0d] got=%h/%h addr=%h exp=%h/%h", i, instr_d, pc_plus4_d, imem_addr, e.instr, e.pc_plus4); end
    end
  endtask
  task automatic test_async_reset;
    stall_d = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++; if (q_count !== CW'(4) || stall_f !== 1'b1) begin bad++; $display("FAIL ar_full got cnt=%0d sf=%b exp 4 1", q_count, stall_f); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (q_count !== '0 || valid_d !== 1'b0 || instr_d !== 32'h0 || pc_plus4_d !== 32'h0 || imem_addr !== 32'h0 || stall_f !== 1'b0) begin bad++; $display("FAIL ar_now got cnt=%0d v=%b i=%h p=%h a=%h sf=%b exp all 0", q_count, valid_d, instr_d, pc_plus4_d, imem_addr, stall_f); end
    @(negedge clk); rst_n = 1'b1; stall_d = 1'b0;
    sb.delete();
    sb.push_back(mk(32'h0)); sb.push_back(mk(32'h4));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      total++; if (instr_d !== e.instr || pc_plus4_d !== e.pc_plus4 || q_count !== '0) begin bad++; $display("FAIL ar_restart[%0d] got=%h/%h cnt=%0d exp=%h/%h 0", i, instr_d, pc_plus4_d, q_count, e.instr, e.pc_plus4); end
    end
  endtask
  initial begin
    test_reset();
    test_first();
    test_stall();
    test_release();
    test_redirect();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
